uart_tx_fifo: RTL

UART transmitter that accepts bytes over a valid/ready handshake, buffers them in a 4-entry FIFO and serialises each as an 8N1 frame on `serial_tx`. It pairs with the receive path on `serial_rx`: the top-level `main` instantiates it to drive its serial output. Frames are sent back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with 4-entry byte FIFO; define UART_TX_PARITY_EN for 8E1 frames (default 8N1)
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       serial_tx,
   output logic       busy,
   output logic [2:0] fifo_count
);

   // Baud counter needs to hold CLKS_PER_BIT-1; never narrower than one bit.
   localparam int BAUD_W_RAW = $clog2(CLKS_PER_BIT + 1);
   localparam int BAUD_W     = (BAUD_W_RAW < 1) ? 1 : BAUD_W_RAW;
   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;
`endif

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift_reg;
`ifdef UART_TX_PARITY_EN
   logic              parity_bit;
`endif

   logic [7:0]        mem [4];
   logic [1:0]        wr_ptr;
   logic [1:0]        rd_ptr;
   logic [7:0]        head;
   logic              fifo_nonempty;
   logic              baud_last;
   logic              push;
   logic              pop;

   // Full only at exactly four entries; count is registered so this is glitch-free.
   assign tx_ready      = (fifo_count != 3'd4);
   assign fifo_nonempty = (fifo_count != 3'd0);
   assign head          = mem[rd_ptr];
   assign baud_last     = (baud_cnt == BAUD_MAX);
   assign push          = tx_valid && tx_ready;

   // The FSM consumes the head byte when it starts a frame: from IDLE, or on
   // the final stop cycle so the next start bit follows with no idle gap.
   assign pop = fifo_nonempty &&
                ((state == S_IDLE) || ((state == S_STOP) && baud_last));

   // FIFO storage; contents need no reset because count/pointers gate reads.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_count <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 3'd1;
            2'b01:   fifo_count <= fifo_count - 3'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Frame sequencer; serial_tx and busy are registered so the line level
   // always matches the state being entered on that edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_idx    <= 3'd0;
         shift_reg  <= 8'd0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
         serial_tx  <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               baud_cnt  <= '0;
               serial_tx <= 1'b1;
               busy      <= 1'b0;
               if (pop) begin
                  shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^head;
`endif
                  state      <= S_START;
                  serial_tx  <= 1'b0;
                  busy       <= 1'b1;
               end
            end

            S_START: begin
               if (baud_last) begin
                  baud_cnt  <= '0;
                  bit_idx   <= 3'd0;
                  state     <= S_DATA;
                  serial_tx <= shift_reg[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state     <= S_PARITY;
                     serial_tx <= parity_bit;
`else
                     state     <= S_STOP;
                     serial_tx <= 1'b1;
`endif
                  end else begin
                     // Next data bit is the one that lands in bit 0 after the shift.
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     serial_tx <= shift_reg[1];
                     bit_idx   <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_last) begin
                  baud_cnt  <= '0;
                  state     <= S_STOP;
                  serial_tx <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
                     parity_bit <= ^head;
`endif
                     state      <= S_START;
                     serial_tx  <= 1'b0;
                     busy       <= 1'b1;
                  end else begin
                     state     <= S_IDLE;
                     serial_tx <= 1'b1;
                     busy      <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state     <= S_IDLE;
               baud_cnt  <= '0;
               serial_tx <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
